mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: STARVE_MAX, default 4, is the number of consecutive data grants allowed while a fetch waits; TIMEOUT, default 16, is the number of wait cycles before a transaction is aborted.
REQ-002 Ports, clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
REQ-003 Fetch port:
- if_req  in  1  fetch request.
- if_addr  in  64  fetch address.
- if_valid  out  1  fetch done pulse.
- if_rdata  out  32  instruction.
REQ-004 Data port:
- d_req  in  1  data request.
- d_we  in  1  1 = store.
- d_addr  in  64  data address.
- d_wdata  in  64  store data.
- d_valid  out  1  data done pulse.
- d_rdata  out  64  load data.
REQ-005 Memory side:
- mem_req  out  1  request.
- mem_we  out  1  write enable.
- mem_addr  out  64  address.
- mem_wdata  out  64  write data.
- mem_ack  in  1  completion.
- mem_rdata  in  64  read data.
REQ-006 Status:
- stall_if  out  1  fetch stall.
- stall_mem  out  1  data stall.
- busy  out  1  transaction in flight.
- err  out  1  sticky timeout flag.

Function
REQ-007 The block SHALL share one single-port memory between the fetch and data requesters using FSM states IDLE, I_WAIT, D_WAIT and RESP.
REQ-008 In IDLE the data port SHALL win if d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX); otherwise fetch SHALL win if if_req=1; otherwise the FSM SHALL stay in IDLE.
REQ-009 On a grant the block SHALL register the winner's address, d_we and d_wdata (zero for fetch) into the mem_* outputs and assert mem_req from the next cycle; mem_we SHALL be 0 for a fetch.
REQ-010 mem_req and mem_* SHALL hold stable in I_WAIT/D_WAIT until mem_ack=1; mem_ack outside a WAIT state SHALL be ignored.
REQ-011 On mem_ack in a WAIT state the FSM SHALL register mem_rdata ([31:0] to if_rdata, or the full 64 bits to d_rdata), drop mem_req next cycle and enter RESP.
REQ-012 RESP SHALL last exactly one cycle, pulse if_valid or d_valid for the completed port, make no grant, then return to IDLE.
REQ-013 The minimum latency from request in IDLE to the done pulse SHALL be 2 cycles (grant at cycle 0, mem_req at cycle 1 with same-cycle ack, done at cycle 2).
REQ-014 Requesters SHALL hold req and payload stable until their done pulse; a req still high in the cycle after RESP is a new request.
REQ-015 starve_cnt (3-bit, saturating at STARVE_MAX) SHALL increment on each data grant while if_req=1, clear on every fetch grant, and hold otherwise.
REQ-016 wait_cnt SHALL clear on entry to a WAIT state and increment each WAIT cycle without ack; at wait_cnt=TIMEOUT-1 without ack the FSM SHALL abort to RESP, return rdata=0, and set err.
REQ-017 If mem_ack and the timeout coincide, mem_ack SHALL win and err SHALL NOT be set.
REQ-018 err SHALL be sticky and cleared only by reset.
REQ-019 The status outputs SHALL be:
- stall_if = if_req & ~if_valid.
- stall_mem = d_req & ~d_valid.
- busy = 1 in I_WAIT, D_WAIT and RESP.

Reset
REQ-020 On reset (asynchronous, active-high) the block SHALL force:
- state to IDLE.
- mem_req, mem_we, if_valid, d_valid and err to 0.
- mem_addr, mem_wdata, if_rdata, d_rdata, starve_cnt and wait_cnt to 0.
REQ-021 Reset mid-transaction SHALL abandon it with no done pulse; the first grant SHALL be possible in the first clock after reset deasserts.

Verification
REQ-022 Single fetch: if_req=1, if_addr=0x40, ack 2 cycles after mem_req with rdata=0x00500093 -> one if_valid pulse, if_rdata=0x00500093, mem_we=0 throughout.
REQ-023 Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD, same-cycle ack -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD, d_valid at cycle 2.
REQ-024 Contention: if_req and d_req both held high, every ack immediate -> grant order D,D,D,D,I,D,... with STARVE_MAX=4.
REQ-025 Timeout: d_req=1, mem_ack never -> mem_req high for exactly 16 cycles, then d_valid=1, d_rdata=0, err=1 and held.
REQ-026 Ack at the timeout edge: mem_ack=1 in wait cycle 15 -> normal completion, err=0.
REQ-027 Reset mid-transaction: reset asserted in D_WAIT -> mem_req=0 immediately, no d_valid pulse, and a fresh if_req is granted in the first cycle after release.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, data, memory and status signals of the
//          mem_port_arbiter into one interface.
// Modports:
//   slave  - the arbiter: takes requests and memory responses, drives
//            done pulses, memory commands and status.
//   master - the environment: requesters plus the memory model.
interface mem_port_arbiter_if;
  // Fetch port
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  // Data port
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_valid;
  logic [63:0] d_rdata;
  // Memory side
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  // Status
  logic        stall_if;
  logic        stall_mem;
  logic        busy;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, busy, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between an instruction-fetch
//          requester and a load/store requester. Data wins by default, but
//          a waiting fetch is guaranteed a slot after STARVE_MAX consecutive
//          data grants. Each transaction waits for mem_ack, or aborts after
//          TIMEOUT wait cycles with zero read data and a sticky err flag.
// Ports:
//   clk   - sole clock
//   reset - asynchronous, active-high
//   bus   - mem_port_arbiter_if.slave (fetch, data, memory and status)
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_port_arbiter_if.slave         bus
);

  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, RESP} state_t;

  state_t          state_q;
  logic [2:0]      starve_cnt_q;
  logic [WCW-1:0]  wait_cnt_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [63:0]     mem_addr_q;
  logic [63:0]     mem_wdata_q;
  logic            if_valid_q;
  logic [31:0]     if_rdata_q;
  logic            d_valid_q;
  logic [63:0]     d_rdata_q;
  logic            err_q;
  logic            busy_q;

  // Grant decision for the IDLE state
  logic data_win;
  logic starve_ok;
  logic timeout_hit;

  assign starve_ok   = (starve_cnt_q < 3'(STARVE_MAX));
  assign data_win    = bus.d_req & (~bus.if_req | starve_ok);
  assign timeout_hit = (wait_cnt_q == WCW'(TIMEOUT - 1));

  // Arbiter FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Done pulses last a single cycle
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (data_win) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b1;
            state_q     <= D_WAIT;
            // Only grants that bypass a waiting fetch count toward starvation
            if (bus.if_req && starve_ok) begin
              starve_cnt_q <= starve_cnt_q + 3'd1;
            end
          end else if (bus.if_req) begin
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= bus.if_addr;
            mem_wdata_q  <= '0;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= I_WAIT;
          end
        end

        I_WAIT, D_WAIT: begin
          // An ack in the timeout cycle still completes normally
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (state_q == I_WAIT) begin
              if_rdata_q <= bus.mem_rdata[31:0];
              if_valid_q <= 1'b1;
            end else begin
              d_rdata_q <= bus.mem_rdata;
              d_valid_q <= 1'b1;
            end
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= RESP;
            if (state_q == I_WAIT) begin
              if_rdata_q <= '0;
              if_valid_q <= 1'b1;
            end else begin
              d_rdata_q <= '0;
              d_valid_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end

        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

  // Stall flags combine the live request with the registered done pulse
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: scoreboard bench for mem_port_arbiter. Drivers push the expected
//          memory command and done response; a monitor pops and compares
//          whenever the DUT raises mem_req or a done pulse.
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } rsp_exp_t;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  int          wait_idx = 0;
  logic [63:0] mem_data_cfg = '0;
  int          d_done_cnt = 0;
  int          done_cnt = 0;
  logic        mem_req_prev = 1'b0;
  mem_exp_t    cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_delay cycles of mem_req (-1 = never)
  always @(negedge clk) begin
    if (bus.mem_req) begin
      bus.mem_ack   = (ack_delay >= 0) && (wait_idx == ack_delay);
      bus.mem_rdata = mem_data_cfg;
      wait_idx++;
    end else begin
      bus.mem_ack = 1'b0;
      wait_idx    = 0;
    end
  end

  // Monitor: grants, command stability and done responses
  always @(negedge clk) begin
    if (reset) begin
      mem_req_prev = 1'b0;
    end else begin
      if (bus.mem_req && !mem_req_prev) begin
        if (exp_mem.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL grant: unexpected mem_req addr 0x%0h", bus.mem_addr);
          cur.we = bus.mem_we; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata;
        end else begin
          cur = exp_mem.pop_front();
          check("grant_we",    64'(bus.mem_we), 64'(cur.we));
          check("grant_addr",  bus.mem_addr,    cur.addr);
          check("grant_wdata", bus.mem_wdata,   cur.wdata);
        end
      end else if (bus.mem_req) begin
        check("hold_we",    64'(bus.mem_we), 64'(cur.we));
        check("hold_addr",  bus.mem_addr,    cur.addr);
        check("hold_wdata", bus.mem_wdata,   cur.wdata);
      end
      mem_req_prev = bus.mem_req;

      if (bus.if_valid || bus.d_valid) begin
        rsp_exp_t e;
        done_cnt++;
        if (bus.d_valid) d_done_cnt++;
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL done: unexpected pulse if_valid=%0b d_valid=%0b", bus.if_valid, bus.d_valid);
        end else begin
          e = exp_rsp.pop_front();
          check("done_port", 64'(bus.d_valid), 64'(e.is_d));
          check("done_both", 64'(bus.if_valid & bus.d_valid), 64'd0);
          if (e.is_d) check("d_rdata", bus.d_rdata, e.data);
          else        check("if_rdata", 64'(bus.if_rdata), e.data);
        end
      end
    end
  end

  // Waits at negedges for the done pulse of one port, bounded
  task automatic wait_done(input bit is_d, output int lat, output int req_cyc);
    lat = 0;
    req_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_req) req_cyc++;
    end while (!(is_d ? bus.d_valid : bus.if_valid) && lat < 100);
    if (lat >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_done: no done pulse within 100 cycles (is_d=%0b)", is_d);
    end
  endtask

  task automatic do_fetch(input logic [63:0] addr, input logic [63:0] rdata,
                          input int delay, input int exp_lat, input int exp_req);
    int lat, rc;
    mem_exp_t m;
    rsp_exp_t r;
    ack_delay = delay;
    mem_data_cfg = rdata;
    m.we = 1'b0; m.addr = addr; m.wdata = '0;
    r.is_d = 1'b0; r.data = {32'd0, rdata[31:0]};
    exp_mem.push_back(m);
    exp_rsp.push_back(r);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    wait_done(1'b0, lat, rc);
    bus.if_req = 1'b0;
    check("fetch_latency", 64'(lat), 64'(exp_lat));
    check("fetch_req_cycles", 64'(rc), 64'(exp_req));
  endtask

  task automatic do_data(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int delay, input logic [63:0] exp_data,
                         input int exp_lat, input int exp_req);
    int lat, rc;
    mem_exp_t m;
    rsp_exp_t r;
    ack_delay = delay;
    mem_data_cfg = rdata;
    m.we = we; m.addr = addr; m.wdata = wdata;
    r.is_d = 1'b1; r.data = exp_data;
    exp_mem.push_back(m);
    exp_rsp.push_back(r);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    wait_done(1'b1, lat, rc);
    bus.d_req = 1'b0;
    check("data_latency", 64'(lat), 64'(exp_lat));
    check("data_req_cycles", 64'(rc), 64'(exp_req));
  endtask

  initial begin
    int start_cnt, cyc, d_before;
    mem_exp_t m;
    rsp_exp_t r;
    bit pattern_d [10];

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req",   64'(bus.mem_req),  64'd0);
    check("rst_mem_we",    64'(bus.mem_we),   64'd0);
    check("rst_mem_addr",  bus.mem_addr,      64'd0);
    check("rst_mem_wdata", bus.mem_wdata,     64'd0);
    check("rst_if_valid",  64'(bus.if_valid), 64'd0);
    check("rst_d_valid",   64'(bus.d_valid),  64'd0);
    check("rst_if_rdata",  64'(bus.if_rdata), 64'd0);
    check("rst_d_rdata",   bus.d_rdata,       64'd0);
    check("rst_err",       64'(bus.err),      64'd0);
    check("rst_busy",      64'(bus.busy),     64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, ack two cycles after mem_req
    do_fetch(64'h40, 64'h0000_0000_0050_0093, 2, 4, 3);
    @(negedge clk);

    // Store with same-cycle ack: done at cycle 2
    do_data(1'b1, 64'h100, 64'hDEAD, 64'hCAFE, 0, 64'hCAFE, 2, 1);
    @(negedge clk);

    // Contention: both held high, immediate acks -> D,D,D,D,I,D,D,D,D,I
    ack_delay = 0;
    mem_data_cfg = 64'h1234_5678_9ABC_DEF0;
    pattern_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      m.we = 1'b0;
      m.addr  = pattern_d[i] ? 64'h300 : 64'h200;
      m.wdata = pattern_d[i] ? 64'h55  : 64'h0;
      r.is_d = pattern_d[i];
      r.data = pattern_d[i] ? 64'h1234_5678_9ABC_DEF0 : 64'h0000_0000_9ABC_DEF0;
      exp_mem.push_back(m);
      exp_rsp.push_back(r);
    end
    start_cnt = done_cnt;
    bus.if_addr = 64'h200;
    bus.d_addr = 64'h300; bus.d_we = 1'b0; bus.d_wdata = 64'h55;
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    @(negedge clk);
    check("contend_stall_if", 64'(bus.stall_if), 64'd1);
    cyc = 1;
    while (done_cnt - start_cnt < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    check("contend_done_count", 64'(done_cnt - start_cnt), 64'd10);
    @(negedge clk);
    check("contend_busy_after", 64'(bus.busy), 64'd0);

    // Ack in the last wait cycle completes normally
    do_data(1'b0, 64'h80, 64'h0, 64'h1122_3344_5566_7788, 15, 64'h1122_3344_5566_7788, 17, 16);
    check("edge_err", 64'(bus.err), 64'd0);
    @(negedge clk);

    // Timeout: no ack -> 16 cycles of mem_req, zero data, sticky err
    do_data(1'b0, 64'h88, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 64'h0, 17, 16);
    check("timeout_err", 64'(bus.err), 64'd1);
    repeat (5) @(negedge clk);
    check("timeout_err_held", 64'(bus.err), 64'd1);
    check("timeout_idle_busy", 64'(bus.busy), 64'd0);
    check("timeout_stall_mem", 64'(bus.stall_mem), 64'd0);

    // Reset during D_WAIT abandons the transaction
    ack_delay = -1;
    m.we = 1'b0; m.addr = 64'h90; m.wdata = 64'h0;
    exp_mem.push_back(m);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h90; bus.d_wdata = 64'h0;
    d_before = d_done_cnt;
    repeat (3) @(negedge clk);
    check("midrst_busy", 64'(bus.busy), 64'd1);
    check("midrst_stall_mem", 64'(bus.stall_mem), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    check("midrst_err_clr", 64'(bus.err), 64'd0);
    check("midrst_busy_clr", 64'(bus.busy), 64'd0);
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_fetch(64'h44, 64'h0000_0000_0000_0013, 0, 2, 1);
    check("midrst_no_d_valid", 64'(d_done_cnt - d_before), 64'd0);
    repeat (2) @(negedge clk);

    check("exp_mem_left", 64'(exp_mem.size()), 64'd0);
    check("exp_rsp_left", 64'(exp_rsp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
